prbs16_checker: RTL and testbench

Self-synchronising checker for the serial stream produced by the 16-bit PRBS generator (polynomial x^16+x^14+x^13+x^11+1, output bit = generator LSB). It sits directly downstream of the generator. It acquires lock without knowing the seed, then flags and counts bit errors. If the error density gets too high, it declares loss of lock and re-acquires.

---
 rtl/prbs16_checker.sv | 224 ++++++++++++++++++++++
 tb/tb_prbs16_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs16_checker.sv
// prbs16_checker
// Self-synchronising checker for the x^16+x^14+x^13+x^11+1 PRBS bit stream.
// It acquires lock from the data alone, counts bit errors while locked, and
// drops back to acquisition when too many errors fall inside one window.

module prbs16_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_bit_in,
    input  logic        i_bit_valid,
    input  logic        i_clear,
    output logic        o_locked,
    output logic        o_err_pulse,
    output logic [15:0] o_err_count,
    output logic [31:0] o_bit_count
);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_CNT_L = 8'(LOCK_COUNT);
    localparam logic [7:0] WIN_LAST_L = 8'(WINDOW - 1);
    localparam logic [7:0] THRESH_L   = 8'(LOSS_THRESH);

    // Next bit predicted by the recurrence b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11].
    function automatic logic prbs_predict(input logic [15:0] hist);
        return hist[15] ^ hist[13] ^ hist[12] ^ hist[10];
    endfunction

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_hist;
    logic [4:0]  r_fill;
    logic [7:0]  r_good;
    logic [7:0]  r_win_bits;
    logic [7:0]  r_win_errs;
    logic        r_locked;
    logic        r_err_pulse;
    logic [15:0] r_err_count;
    logic [31:0] r_bit_count;

    logic [15:0] w_hist_next;
    logic [4:0]  w_fill_next;
    logic [7:0]  w_good_next;
    logic [7:0]  w_win_bits_next;
    logic [7:0]  w_win_errs_next;
    logic        w_err_pulse_next;
    logic [15:0] w_err_count_next;
    logic [31:0] w_bit_count_next;

    logic        w_pred;
    logic        w_match;
    logic [15:0] w_hist_rx;
    logic [15:0] w_hist_pred;
    logic        w_filled;
    logic [7:0]  w_good_run;
    logic [7:0]  w_win_errs_inc;
    logic        w_lock_hit;
    logic        w_loss_hit;

    assign w_pred         = prbs_predict(r_hist);
    assign w_match        = (i_bit_in == w_pred);
    assign w_hist_rx      = {r_hist[14:0], i_bit_in};
    assign w_hist_pred    = {r_hist[14:0], w_pred};
    assign w_filled       = (r_fill == 5'd16);
    // An all-zero history satisfies the recurrence trivially, so it never counts as a good run.
    assign w_good_run     = (w_match && (w_hist_rx != 16'h0000)) ? (r_good + 8'd1) : 8'd0;
    assign w_win_errs_inc = w_match ? r_win_errs : (r_win_errs + 8'd1);
    assign w_lock_hit     = w_filled && (w_good_run == LOCK_CNT_L);
    assign w_loss_hit     = (w_win_errs_inc == THRESH_L);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: lock on a full good run, unlock on too many window errors.
    always_comb begin
        w_state_next = r_state;
        if (i_bit_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_lock_hit) begin
                        w_state_next = ST_LOCKED;
                    end else begin
                        w_state_next = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (w_loss_hit) begin
                        w_state_next = ST_SEARCH;
                    end else begin
                        w_state_next = ST_LOCKED;
                    end
                end
                default: begin
                    w_state_next = ST_SEARCH;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Output and datapath logic: history, acquisition/window counters and error statistics.
    always_comb begin
        w_hist_next      = r_hist;
        w_fill_next      = r_fill;
        w_good_next      = r_good;
        w_win_bits_next  = r_win_bits;
        w_win_errs_next  = r_win_errs;
        w_err_pulse_next = 1'b0;
        w_err_count_next = r_err_count;
        w_bit_count_next = r_bit_count;

        if (i_bit_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    w_hist_next = w_hist_rx;
                    if (!w_filled) begin
                        w_fill_next = r_fill + 5'd1;
                    end else begin
                        w_good_next = w_good_run;
                        if (w_lock_hit) begin
                            w_win_bits_next = 8'd0;
                            w_win_errs_next = 8'd0;
                        end else begin
                            w_win_bits_next = r_win_bits;
                            w_win_errs_next = r_win_errs;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (r_bit_count != 32'hFFFF_FFFF) begin
                        w_bit_count_next = r_bit_count + 32'd1;
                    end else begin
                        w_bit_count_next = r_bit_count;
                    end
                    // On a mismatch the prediction is kept so one flipped bit costs one count.
                    if (!w_match) begin
                        w_err_pulse_next = 1'b1;
                        w_hist_next      = w_hist_pred;
                        if (r_err_count != 16'hFFFF) begin
                            w_err_count_next = r_err_count + 16'd1;
                        end else begin
                            w_err_count_next = r_err_count;
                        end
                    end else begin
                        w_hist_next = w_hist_rx;
                    end
                    // Threshold is checked before any window wrap on the same bit.
                    if (w_loss_hit) begin
                        w_fill_next     = 5'd0;
                        w_good_next     = 8'd0;
                        w_win_bits_next = 8'd0;
                        w_win_errs_next = 8'd0;
                    end else if (r_win_bits == WIN_LAST_L) begin
                        w_win_bits_next = 8'd0;
                        w_win_errs_next = 8'd0;
                    end else begin
                        w_win_bits_next = r_win_bits + 8'd1;
                        w_win_errs_next = w_win_errs_inc;
                    end
                end
                default: begin
                    w_fill_next = 5'd0;
                    w_good_next = 8'd0;
                end
            endcase
        end else begin
            w_err_pulse_next = 1'b0;
        end

        if (i_clear) begin
            w_err_count_next = 16'd0;
            w_bit_count_next = 32'd0;
        end else begin
            w_err_count_next = w_err_count_next;
            w_bit_count_next = w_bit_count_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hist      <= 16'h0000;
            r_fill      <= 5'd0;
            r_good      <= 8'd0;
            r_win_bits  <= 8'd0;
            r_win_errs  <= 8'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= 16'd0;
            r_bit_count <= 32'd0;
        end else begin
            r_hist      <= w_hist_next;
            r_fill      <= w_fill_next;
            r_good      <= w_good_next;
            r_win_bits  <= w_win_bits_next;
            r_win_errs  <= w_win_errs_next;
            r_locked    <= (w_state_next == ST_LOCKED);
            r_err_pulse <= w_err_pulse_next;
            r_err_count <= w_err_count_next;
            r_bit_count <= w_bit_count_next;
        end
    end

    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_err_count = r_err_count;
    assign o_bit_count = r_bit_count;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed testbench for prbs16_checker: acquisition, isolated errors,
// loss of lock, window wrap, CLEAR interaction, reset and corner streams.

module tb_prbs16_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        valid;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] lfsr;

    prbs16_checker #(
        .LOCK_COUNT (32),
        .WINDOW     (64),
        .LOSS_THRESH(8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_bit_in   (bit_in),
        .i_bit_valid(valid),
        .i_clear    (clear),
        .o_locked   (locked),
        .o_err_pulse(err_pulse),
        .o_err_count(err_count),
        .o_bit_count(bit_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs and sample outputs 1 unit after the edge.
    task automatic step(input logic b, input logic v, input logic c);
        bit_in = b;
        valid  = v;
        clear  = c;
        @(posedge clk);
        #1;
    endtask

    // Reference generator: output LSB, feedback s0^s2^s3^s5 into bit 15.
    task automatic gen(output logic b);
        b    = lfsr[0];
        lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    endtask

    // Main directed sequence.
    initial begin
        logic b;
        logic err;
        int   rise;
        int   pulses;
        int   dropped;
        int   nvalid;

        rst = 1'b1; bit_in = 1'b0; valid = 1'b0; clear = 1'b0;

        // Reset held for 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_bit_count", bit_count,      32'd0);
        rst = 1'b0;

        // Acquisition from the 0xACE1-seeded stream.
        lfsr = 16'hACE1;
        rise = 0;
        for (int i = 1; i <= 48; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (locked && rise == 0) rise = i;
        end
        check("acq_rise_bit", 32'(rise), 32'd48);
        for (int i = 0; i < 100; i++) begin gen(b); step(b, 1'b1, 1'b0); end
        check("acq_bit_count", bit_count,      32'd100);
        check("acq_err_count", 32'(err_count), 32'd0);
        check("acq_locked",    32'(locked),    32'd1);

        // Single isolated error on locked bit 10.
        for (int i = 1; i <= 10; i++) begin
            gen(b);
            step((i == 10) ? ~b : b, 1'b1, 1'b0);
            if (i == 9) check("single_pre_pulse", 32'(err_pulse), 32'd0);
        end
        check("single_pulse",     32'(err_pulse), 32'd1);
        check("single_err_count", 32'(err_count), 32'd1);
        check("single_locked",    32'(locked),    32'd1);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            pulses += int'(err_pulse);
        end
        check("single_no_more_pulses", 32'(pulses),    32'd0);
        check("single_err_count_end",  32'(err_count), 32'd1);
        check("single_bit_count_end",  bit_count,      32'd310);

        // Align to a window boundary (310 + 10 = 5 * 64), then clear counters.
        for (int i = 0; i < 10; i++) begin gen(b); step(b, 1'b1, 1'b0); end
        step(1'b0, 1'b0, 1'b1);
        check("clr_err_count", 32'(err_count), 32'd0);
        check("clr_bit_count", bit_count,      32'd0);
        check("clr_locked",    32'(locked),    32'd1);

        // Loss of lock: 8 errors on even bits 0..14 of one window.
        for (int i = 0; i < 15; i++) begin
            gen(b);
            step((i % 2 == 0) ? ~b : b, 1'b1, 1'b0);
            if (i == 12) check("loss_locked_at_7", 32'(locked), 32'd1);
        end
        check("loss_locked_at_8", 32'(locked),    32'd0);
        check("loss_err_count",   32'(err_count), 32'd8);
        rise = 0;
        for (int i = 1; i <= 48; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (locked && rise == 0) rise = i;
        end
        check("relock_rise_bit",  32'(rise),      32'd48);
        check("relock_err_count", 32'(err_count), 32'd8);
        check("relock_bit_count", bit_count,      32'd15);

        // Window wrap: 7 errors per window; windows 1 and 2 errors are back to back across the wrap.
        step(1'b0, 1'b0, 1'b1);
        pulses  = 0;
        dropped = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++) begin
                err = ((w != 1) && (i < 7)) || ((w == 1) && (i >= 57));
                gen(b);
                step(err ? ~b : b, 1'b1, 1'b0);
                pulses += int'(err_pulse);
                if (!locked) dropped = 1;
            end
        end
        check("wrap_dropped",   32'(dropped),   32'd0);
        check("wrap_err_count", 32'(err_count), 32'd21);
        check("wrap_pulses",    32'(pulses),    32'd21);
        check("wrap_bit_count", bit_count,      32'd192);

        // CLEAR on the same edge as an error.
        gen(b);
        step(~b, 1'b1, 1'b1);
        check("clr_err_pulse",     32'(err_pulse), 32'd1);
        check("clr_err_err_count", 32'(err_count), 32'd0);
        check("clr_err_bit_count", bit_count,      32'd0);
        gen(b);
        step(b, 1'b1, 1'b0);
        check("clr_after_pulse",     32'(err_pulse), 32'd0);
        check("clr_after_bit_count", bit_count,      32'd1);

        // Reset mid-operation overrides CLEAR and BIT_VALID.
        rst = 1'b1;
        gen(b);
        step(~b, 1'b1, 1'b1);
        rst = 1'b0;
        check("mid_rst_locked",    32'(locked),    32'd0);
        check("mid_rst_err_pulse", 32'(err_pulse), 32'd0);
        check("mid_rst_bit_count", bit_count,      32'd0);

        // All-zero stream must never lock.
        dropped = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (locked) dropped = 1;
        end
        check("zeros_never_lock", 32'(dropped),   32'd0);
        check("zeros_err_count",  32'(err_count), 32'd0);

        // BIT_VALID high one cycle in three; invalid cycles carry random data.
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst    = 1'b0;
        lfsr   = 16'hACE1;
        nvalid = 0;
        rise   = 0;
        for (int c = 0; c < 1000 && nvalid < 48; c++) begin
            if (c % 3 == 0) begin
                gen(b);
                step(b, 1'b1, 1'b0);
                nvalid++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            if (locked && rise == 0) rise = nvalid;
        end
        check("gap_rise_valid_bit", 32'(rise), 32'd48);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("gap_hold_locked",    32'(locked),    32'd1);
        check("gap_hold_pulse",     32'(err_pulse), 32'd0);
        check("gap_hold_bit_count", bit_count,      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
